// File: rtl/cplx_integrate_dump.sv
// Integrate-and-dump for complex I/Q products: accumulates ACC_LEN valid samples, then
// rounds, shifts and saturates the block sum onto a valid/ready output register.
module cplx_integrate_dump #(
    parameter int unsigned DATA_W  = 37,
    parameter int unsigned ACC_LEN = 16,
    parameter int unsigned SHIFT   = 4,
    parameter int unsigned OUT_W   = 18
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic [DATA_W-1:0] data_i_i,
    input  logic [DATA_W-1:0] data_q_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic [OUT_W-1:0]  data_i_o,
    output logic [OUT_W-1:0]  data_q_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sat_o,
    output logic              drop_o
);

    localparam int unsigned ACC_W = DATA_W + $clog2(ACC_LEN);
    localparam int unsigned CNT_W = $clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    // Rounding constant and clip bounds, all in ACC_W+1 bits.
    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    s1_valid_q;
    logic signed [ACC_W-1:0] s1_i_q, s1_q_q;
    logic [OUT_W-1:0]        out_i_q, out_q_q;
    logic                    out_valid_q, sat_q, drop_q;

    logic signed [ACC_W-1:0] ext_i, ext_q, sum_i, sum_q;
    logic                    take, dump, out_load;
    logic [OUT_W:0]          rs_i, rs_q;

    // Returns {clip, value}.
    function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W:0] r;
        r = ($signed({s[ACC_W-1], s}) + RND) >>> SHIFT;
        if (r > SAT_MAX) begin
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (r < SAT_MIN) begin
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        end
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    always_comb begin
        ext_i    = {{(ACC_W - DATA_W){data_i_i[DATA_W-1]}}, data_i_i};
        ext_q    = {{(ACC_W - DATA_W){data_q_i[DATA_W-1]}}, data_q_i};
        sum_i    = acc_i_q + ext_i;
        sum_q    = acc_q_q + ext_q;
        take     = valid_i && !clear_i;
        dump     = take && (cnt_q == CNT_LAST);
        out_load = s1_valid_q && (!out_valid_q || ready_i);
        rs_i     = round_sat(s1_i_q);
        rs_q     = round_sat(s1_q_q);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
        end else if (dump) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
        end else if (take) begin
            acc_i_q <= sum_i;
            acc_q_q <= sum_q;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Stage 1 holds one finished sum; a dump that finds it occupied and stalled is dropped.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            s1_valid_q <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (clear_i) begin
                s1_valid_q <= 1'b0;
            end else if (dump) begin
                if (!s1_valid_q || out_load) begin
                    s1_valid_q <= 1'b1;
                    s1_i_q     <= sum_i;
                    s1_q_q     <= sum_q;
                end else begin
                    drop_q <= 1'b1;
                end
            end else if (out_load) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            sat_q       <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_i_q     <= rs_i[OUT_W-1:0];
            out_q_q     <= rs_q[OUT_W-1:0];
            sat_q       <= rs_i[OUT_W] | rs_q[OUT_W];
        end else if (ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign data_i_o = out_i_q;
    assign data_q_o = out_q_q;
    assign valid_o  = out_valid_q;
    assign sat_o    = sat_q;
    assign drop_o   = drop_q;

endmodule

// File: tb/tb_cplx_integrate_dump.sv
// Scoreboard bench for cplx_integrate_dump with ACC_LEN=4, SHIFT=2, OUT_W=18.
module tb_cplx_integrate_dump;

    localparam int DW = 37;
    localparam int OW = 18;

    logic                 clk = 1'b0;
    logic                 arstn;
    logic [DW-1:0]        data_i, data_q;
    logic                 valid, clear, ready;
    logic signed [OW-1:0] out_i, out_q;
    logic                 out_valid, sat, drop;

    cplx_integrate_dump #(
        .DATA_W (DW),
        .ACC_LEN(4),
        .SHIFT  (2),
        .OUT_W  (OW)
    ) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .data_i_i(data_i),
        .data_q_i(data_q),
        .valid_i (valid),
        .clear_i (clear),
        .data_i_o(out_i),
        .data_q_o(out_q),
        .valid_o (out_valid),
        .ready_i (ready),
        .sat_o   (sat),
        .drop_o  (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint i;
        longint q;
        longint sat;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     drop_cnt = 0;
    longint m_acc_i = 0, m_acc_q = 0;
    int     m_cnt = 0;
    bit     chk_lat = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint round_clip(input longint s, output longint clip);
        longint r;
        r = (s + 2) >>> 2;
        clip = 0;
        if (r > 131071) begin
            r = 131071;
            clip = 1;
        end else if (r < -131072) begin
            r = -131072;
            clip = 1;
        end
        return r;
    endfunction

    // One input cycle plus the reference accumulator.
    task automatic drive(input bit v, input longint i, input longint q, input bit clr);
        exp_t   e;
        longint ci, cq;
        @(posedge clk);
        #1;
        valid  = v;
        clear  = clr;
        data_i = DW'(i);
        data_q = DW'(q);
        if (clr) begin
            m_acc_i = 0;
            m_acc_q = 0;
            m_cnt   = 0;
        end else if (v) begin
            if (m_cnt == 3) begin
                e.i   = round_clip(m_acc_i + i, ci);
                e.q   = round_clip(m_acc_q + q, cq);
                e.sat = ci | cq;
                e.cyc = chk_lat ? cyc + 2 : -1;
                sb.push_back(e);
                m_acc_i = 0;
                m_acc_q = 0;
                m_cnt   = 0;
            end else begin
                m_acc_i += i;
                m_acc_q += q;
                m_cnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (drop) drop_cnt++;
        if (arstn && out_valid && ready) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("out_i", longint'(out_i), e.i);
                check_val("out_q", longint'(out_q), e.q);
                check_val("sat", longint'(sat), e.sat);
                if (e.cyc >= 0) check_val("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        int r_cyc;
        arstn  = 1'b0;
        valid  = 1'b0;
        clear  = 1'b0;
        ready  = 1'b1;
        data_i = '0;
        data_q = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", longint'(out_valid), 0);
        check_val("rst_i", longint'(out_i), 0);
        check_val("rst_q", longint'(out_q), 0);
        check_val("rst_sat", longint'(sat), 0);
        check_val("rst_drop", longint'(drop), 0);
        arstn = 1'b1;

        // Basic sum
        for (int k = 1; k <= 4; k++) drive(1'b1, k, -k, 1'b0);
        idle(4);

        // Gapped input
        drive(1'b1, 1, -1, 1'b0);
        idle(1);
        drive(1'b1, 2, -2, 1'b0);
        idle(2);
        drive(1'b1, 3, -3, 1'b0);
        idle(1);
        drive(1'b1, 4, -4, 1'b0);
        idle(4);

        // Saturation
        for (int k = 0; k < 4; k++) drive(1'b1, 64'sd1 <<< 20, -(64'sd1 <<< 20), 1'b0);
        idle(4);
        check_val("sb_after_sat", sb.size(), 0);

        // Backpressure and drop
        ready   = 1'b0;
        chk_lat = 1'b0;
        for (int k = 0; k < 12; k++) drive(1'b1, 4, 0, 1'b0);
        idle(3);
        check_val("bp_valid_held", longint'(out_valid), 1);
        check_val("bp_data_held", longint'(out_i), 4);
        check_val("drop_count", drop_cnt, 1);
        check_val("bp_sb_size", sb.size(), 3);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        ready = 1'b1;
        r_cyc = cyc;
        if (sb.size() == 2) begin
            sb[0].cyc = r_cyc;
            sb[1].cyc = r_cyc + 1;
        end
        idle(3);
        check_val("bp_drained", sb.size(), 0);
        chk_lat = 1'b1;

        // Clear discards partial block and the coincident sample
        drive(1'b1, 100, 0, 1'b0);
        drive(1'b1, 100, 0, 1'b0);
        drive(1'b1, 100, 0, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 8, 0, 1'b0);
        idle(4);
        check_val("sb_after_clear", sb.size(), 0);

        // Reset mid-operation with a held result and cnt=2
        ready   = 1'b0;
        chk_lat = 1'b0;
        for (int k = 0; k < 6; k++) drive(1'b1, 4, 0, 1'b0);
        idle(2);
        check_val("pre_rst_valid", longint'(out_valid), 1);
        @(posedge clk);
        #3;
        arstn = 1'b0;
        #1;
        check_val("arst_valid", longint'(out_valid), 0);
        check_val("arst_i", longint'(out_i), 0);
        check_val("arst_q", longint'(out_q), 0);
        check_val("arst_sat", longint'(sat), 0);
        check_val("arst_drop", longint'(drop), 0);
        sb.delete();
        m_acc_i = 0;
        m_acc_q = 0;
        m_cnt   = 0;
        @(negedge clk);
        arstn   = 1'b1;
        ready   = 1'b1;
        chk_lat = 1'b1;
        for (int k = 0; k < 4; k++) drive(1'b1, 4, 0, 1'b0);
        idle(4);

        check_val("final_sb_empty", sb.size(), 0);
        check_val("final_drop_count", drop_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
